// File: rtl/reg_arb_pkg.sv
// -----------------------------------------------------------------------------
// reg_arb_pkg
// Shared definitions for the register-file write arbiter:
//   - default widths (register number, data, requester count)
//   - write-sequencer state encoding
//   - idx_w(): width of an index able to address n items (min 1 bit)
// -----------------------------------------------------------------------------
package reg_arb_pkg;

  localparam int unsigned ARB_NREQ   = 4;
  localparam int unsigned ARB_DATA_W = 32;
  localparam int unsigned ARB_ADDR_W = 5;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_GAP   = 2'd2
  } arb_state_e;

  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Round-robin grant selection. Priority starts at the pointer and wraps
// modulo NREQ; after an accept the pointer moves to just past the winner.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   en         : grants allowed this cycle
//   req[NREQ]  : request vector
//   grant[NREQ]: one-hot (or zero) grant; a grant is always an accept
// -----------------------------------------------------------------------------
module rr_arbiter
  import reg_arb_pkg::*;
#(
  parameter int unsigned NREQ = ARB_NREQ
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            en,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] grant
);

  localparam int unsigned PTR_W = idx_w(NREQ);

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [PTR_W-1:0] idx;
  logic [PTR_W-1:0] win;
  logic [NREQ-1:0]  grant_raw;

  // Scan from lowest to highest priority so the highest-priority request
  // found last overwrites the others: no "found" flag needed.
  // NOTE: every variable in always_comb gets a default first, so no path
  // leaves it unassigned and no latch is inferred.
  always_comb begin
    grant_raw = '0;
    win       = '0;
    idx       = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = PTR_W'((int'(ptr_q) + k) % NREQ);
      if (req[idx]) begin
        grant_raw      = '0;
        grant_raw[idx] = 1'b1;
        win            = idx;
      end
    end
  end

  assign grant = en ? grant_raw : '0;

  always_comb begin
    ptr_d = ptr_q;
    if (en && (|req)) begin
      ptr_d = (win == PTR_W'(NREQ - 1)) ? '0 : win + PTR_W'(1);
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_d;
  end

endmodule

// File: rtl/reg_write_arbiter.sv
// -----------------------------------------------------------------------------
// reg_write_arbiter
// Arbitrates NREQ writeback requesters onto one register-file write port and
// keeps a pending-write scoreboard.
// Ports:
//   clk, rst              : clock, asynchronous active-high reset
//   req_valid/req_ready   : per-requester handshake (ready is one-hot or zero)
//   req_reg/req_data      : packed per-requester register number / data
//   wr_strobe/wr_reg/data : register-file write port, captured on strobe rise
//   pend_set/pend_reg     : issue stage marks a register as awaiting writeback
//   busy_mask             : registered scoreboard, bit r = write to r pending
// Writes to register 0 are accepted and dropped. Each write is a one-cycle
// strobe followed by a low gap cycle so back-to-back writes stay separate.
// -----------------------------------------------------------------------------
module reg_write_arbiter
  import reg_arb_pkg::*;
#(
  parameter int unsigned NREQ   = ARB_NREQ,
  parameter int unsigned DATA_W = ARB_DATA_W,
  parameter int unsigned ADDR_W = ARB_ADDR_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_valid,
  output logic [NREQ-1:0]        req_ready,
  input  logic [NREQ*ADDR_W-1:0] req_reg,
  input  logic [NREQ*DATA_W-1:0] req_data,
  output logic                   wr_strobe,
  output logic [ADDR_W-1:0]      wr_reg,
  output logic [DATA_W-1:0]      wr_data,
  input  logic                   pend_set,
  input  logic [ADDR_W-1:0]      pend_reg,
  output logic [2**ADDR_W-1:0]   busy_mask
);

  arb_state_e            state_q, state_d;
  logic                  wr_strobe_q, wr_strobe_d;
  logic [ADDR_W-1:0]     wr_reg_q, wr_reg_d;
  logic [DATA_W-1:0]     wr_data_q, wr_data_d;
  logic [2**ADDR_W-1:0]  busy_q, busy_d;

  logic                  accept_en;
  logic                  transfer;
  logic [ADDR_W-1:0]     sel_reg;
  logic [DATA_W-1:0]     sel_data;

  // Reset is gated in explicitly so ready stays low for the whole reset.
  assign accept_en = !rst && (state_q != ST_WRITE);

  rr_arbiter #(.NREQ(NREQ)) u_rr_arbiter (
    .clk   (clk),
    .rst   (rst),
    .en    (accept_en),
    .req   (req_valid),
    .grant (req_ready)
  );

  assign transfer = |(req_valid & req_ready);

  always_comb begin
    sel_reg  = '0;
    sel_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (req_ready[i]) begin
        sel_reg  = req_reg[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    wr_reg_d  = wr_reg_q;
    wr_data_d = wr_data_q;
    unique case (state_q)
      ST_IDLE, ST_GAP: begin
        // A register-0 transfer is consumed here without latching anything.
        if (transfer && (sel_reg != '0)) begin
          state_d   = ST_WRITE;
          wr_reg_d  = sel_reg;
          wr_data_d = sel_data;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WRITE: state_d = ST_GAP;
      default:  state_d = ST_IDLE;
    endcase
    // Registered decode of the next state keeps the strobe glitch-free.
    wr_strobe_d = (state_d == ST_WRITE);
  end

  // Clear on the edge ending WRITE; a simultaneous new issue is applied
  // afterwards so it wins. Bit 0 never records anything.
  always_comb begin
    busy_d = busy_q;
    if (state_q == ST_WRITE) busy_d[wr_reg_q] = 1'b0;
    if (pend_set)            busy_d[pend_reg] = 1'b1;
    busy_d[0] = 1'b0;
  end

  // NOTE: the scoreboard is a flop vector, not a RAM, so it is reset like
  // any other state; an unreset stale bit would stall issue indefinitely.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      wr_strobe_q <= 1'b0;
      wr_reg_q    <= '0;
      wr_data_q   <= '0;
      busy_q      <= '0;
    end else begin
      state_q     <= state_d;
      wr_strobe_q <= wr_strobe_d;
      wr_reg_q    <= wr_reg_d;
      wr_data_q   <= wr_data_d;
      busy_q      <= busy_d;
    end
  end

  assign wr_strobe = wr_strobe_q;
  assign wr_reg    = wr_reg_q;
  assign wr_data   = wr_data_q;
  assign busy_mask = busy_q;

endmodule

// File: tb/tb_reg_write_arbiter.sv
// -----------------------------------------------------------------------------
// tb_reg_write_arbiter
// Directed bench for reg_write_arbiter with default parameters: reset, single
// write, register-0 discard, scoreboard set/clear race, reset mid-write, and
// a table-driven round-robin fairness run.
// -----------------------------------------------------------------------------
module tb_reg_write_arbiter;

  localparam int NREQ   = 4;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  logic                   clk;
  logic                   rst;
  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*ADDR_W-1:0] req_reg;
  logic [NREQ*DATA_W-1:0] req_data;
  logic                   wr_strobe;
  logic [ADDR_W-1:0]      wr_reg;
  logic [DATA_W-1:0]      wr_data;
  logic                   pend_set;
  logic [ADDR_W-1:0]      pend_reg;
  logic [2**ADDR_W-1:0]   busy_mask;

  reg_write_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_reg   (req_reg),
    .req_data  (req_data),
    .wr_strobe (wr_strobe),
    .wr_reg    (wr_reg),
    .wr_data   (wr_data),
    .pend_set  (pend_set),
    .pend_reg  (pend_reg),
    .busy_mask (busy_mask)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_req(input int i, input logic [ADDR_W-1:0] r, input logic [DATA_W-1:0] d);
    req_reg[i*ADDR_W +: ADDR_W] = r;
    req_data[i*DATA_W +: DATA_W] = d;
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [NREQ-1:0]      valid;
    logic                 pset;
    logic [ADDR_W-1:0]    preg;
    logic [NREQ-1:0]      exp_ready;  // combinational, before the edge
    logic                 exp_strobe; // after the edge
    logic [ADDR_W-1:0]    exp_reg;
    logic [DATA_W-1:0]    exp_data;
    logic [2**ADDR_W-1:0] exp_busy;
  } vec_t;

  localparam int NVEC = 12;
  vec_t vecs [NVEC];

  initial begin
    // Fairness run: requester i targets register i+1 with data 0xA0+i.
    vecs[0]  = '{4'hF, 1'b1, 5'd2, 4'b0001, 1'b1, 5'd1, 32'hA0, 32'h0000_0004};
    vecs[1]  = '{4'hF, 1'b0, 5'd0, 4'b0000, 1'b0, 5'd1, 32'hA0, 32'h0000_0004};
    vecs[2]  = '{4'hF, 1'b1, 5'd4, 4'b0010, 1'b1, 5'd2, 32'hA1, 32'h0000_0014};
    vecs[3]  = '{4'hF, 1'b0, 5'd0, 4'b0000, 1'b0, 5'd2, 32'hA1, 32'h0000_0010};
    vecs[4]  = '{4'hF, 1'b0, 5'd0, 4'b0100, 1'b1, 5'd3, 32'hA2, 32'h0000_0010};
    vecs[5]  = '{4'hF, 1'b1, 5'd0, 4'b0000, 1'b0, 5'd3, 32'hA2, 32'h0000_0010};
    vecs[6]  = '{4'hF, 1'b0, 5'd0, 4'b1000, 1'b1, 5'd4, 32'hA3, 32'h0000_0010};
    vecs[7]  = '{4'hF, 1'b0, 5'd0, 4'b0000, 1'b0, 5'd4, 32'hA3, 32'h0000_0000};
    vecs[8]  = '{4'hF, 1'b1, 5'd3, 4'b0001, 1'b1, 5'd1, 32'hA0, 32'h0000_0008};
    vecs[9]  = '{4'hF, 1'b0, 5'd0, 4'b0000, 1'b0, 5'd1, 32'hA0, 32'h0000_0008};
    vecs[10] = '{4'h0, 1'b0, 5'd0, 4'b0000, 1'b0, 5'd1, 32'hA0, 32'h0000_0008};
    vecs[11] = '{4'h0, 1'b0, 5'd0, 4'b0000, 1'b0, 5'd1, 32'hA0, 32'h0000_0008};

    rst       = 1'b1;
    req_valid = '0;
    req_reg   = '0;
    req_data  = '0;
    pend_set  = 1'b0;
    pend_reg  = '0;

    // Reset state, with requests present to show ready is held low.
    #1;
    req_valid = 4'hF;
    #1;
    check("rst_ready",  req_ready, 4'b0000);
    check("rst_strobe", wr_strobe, 1'b0);
    check("rst_wr_reg", wr_reg,    5'd0);
    check("rst_wr_data", wr_data,  32'h0);
    check("rst_busy",   busy_mask, 32'h0);
    tick();
    rst       = 1'b0;
    req_valid = '0;
    tick();

    // Single write: requester 0, register 3, data 0x1234.
    set_req(0, 5'd3, 32'h1234);
    req_valid = 4'b0001;
    #1;
    check("single_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    check("single_strobe_hi", wr_strobe, 1'b1);
    check("single_wr_reg",    wr_reg,    5'd3);
    check("single_wr_data",   wr_data,   32'h1234);
    tick();
    check("single_strobe_gap", wr_strobe, 1'b0);
    tick();
    check("single_strobe_idle", wr_strobe, 1'b0);

    // Register 0 from requester 2 (pointer is now 1): accepted, dropped.
    set_req(2, 5'd0, 32'hFFFF);
    req_valid = 4'b0100;
    #1;
    check("reg0_ready", req_ready, 4'b0100);
    tick();
    req_valid = '0;
    check("reg0_no_strobe", wr_strobe, 1'b0);
    check("reg0_wr_reg",    wr_reg,    5'd3);
    check("reg0_wr_data",   wr_data,   32'h1234);
    tick();
    check("reg0_no_strobe_late", wr_strobe, 1'b0);

    // Scoreboard: mark 7 pending, then re-issue 7 on the edge ending its write.
    pend_set = 1'b1;
    pend_reg = 5'd7;
    tick();
    pend_set = 1'b0;
    check("sb_set", busy_mask, 32'h0000_0080);
    set_req(0, 5'd7, 32'h77);
    req_valid = 4'b0001;
    #1;
    check("sb_wrap_ready", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    check("sb_strobe", wr_strobe, 1'b1);
    check("sb_wr_reg", wr_reg,    5'd7);
    pend_set = 1'b1;
    pend_reg = 5'd7;
    tick();
    pend_set = 1'b0;
    check("sb_set_wins", busy_mask, 32'h0000_0080);
    check("sb_strobe_gap", wr_strobe, 1'b0);

    // Reset during WRITE (pointer is now 1).
    set_req(1, 5'd5, 32'h55);
    req_valid = 4'b0010;
    tick();
    req_valid = '0;
    check("rmw_strobe_hi", wr_strobe, 1'b1);
    #1;
    rst = 1'b1;
    #1;
    check("rmw_strobe_drop", wr_strobe, 1'b0);
    check("rmw_busy",        busy_mask, 32'h0);
    check("rmw_wr_reg",      wr_reg,    5'd0);
    tick();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      tick();
      check("rmw_no_strobe_after", wr_strobe, 1'b0);
    end

    // Fairness table.
    for (int i = 0; i < NREQ; i++) set_req(i, ADDR_W'(i + 1), DATA_W'(32'hA0 + i));
    for (int v = 0; v < NVEC; v++) begin
      req_valid = vecs[v].valid;
      pend_set  = vecs[v].pset;
      pend_reg  = vecs[v].preg;
      #1;
      check($sformatf("vec%0d_ready", v), req_ready, vecs[v].exp_ready);
      tick();
      pend_set = 1'b0;
      check($sformatf("vec%0d_strobe", v),  wr_strobe, vecs[v].exp_strobe);
      check($sformatf("vec%0d_wr_reg", v),  wr_reg,    vecs[v].exp_reg);
      check($sformatf("vec%0d_wr_data", v), wr_data,   vecs[v].exp_data);
      check($sformatf("vec%0d_busy", v),    busy_mask, vecs[v].exp_busy);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
